// File: rtl/score_pkg.sv
// Shared types and constants for the score overlay.
//   bcd_digit_t  : one BCD digit
//   seg7_t       : segment vector, bit order {g,f,e,d,c,b,a}
//   SEG7_LUT     : segment encodings for digits 0-9
//   conv_state_t : states of the sequential binary-to-BCD engine
//   seg7_decode  : digit to segments, non-decimal nibbles light nothing
package score_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_t;

  function automatic seg7_t seg7_decode(bcd_digit_t d);
    if (d > 4'd9) begin
      return '0;
    end
    return SEG7_LUT[d];
  endfunction

endpackage

// File: rtl/score_overlay_if.sv
// Score and pixel-stream bundle for score_overlay.
//   score            : binary score from the score calculator
//   x_pixel, y_pixel : current pixel coordinates
//   de_in, rgb_in    : upstream display enable and 4:4:4 colour
//   de_out, rgb_out  : composited stream, one cycle later
//   busy             : BCD conversion in progress
// master drives the upstream side, slave is the overlay.
interface score_overlay_if;
  logic [7:0]  score;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic        de_in;
  logic [11:0] rgb_in;
  logic        de_out;
  logic [11:0] rgb_out;
  logic        busy;

  modport master (
    output score, x_pixel, y_pixel, de_in, rgb_in,
    input  de_out, rgb_out, busy
  );

  modport slave (
    input  score, x_pixel, y_pixel, de_in, rgb_in,
    output de_out, rgb_out, busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter for an 8-bit value.
//   clk_25MHz, reset : clock, asynchronous active-high reset
//   start            : accepted only while idle; latches bin
//   bin              : binary input
//   busy             : high in SHIFT and DONE
//   done             : one-cycle strobe in DONE; digits valid then
//   hundreds/tens/ones : conversion result
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output bcd_digit_t hundreds,
  output bcd_digit_t tens,
  output bcd_digit_t ones
);

  conv_state_t state_q, state_d;
  // {hundreds, tens, ones, binary}
  logic [19:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] adj;

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    adj     = sr_q[19:8];
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_d    = {12'd0, bin};
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        busy = 1'b1;
        for (int n = 0; n < 3; n++) begin
          if (adj[n*4 +: 4] >= 4'd5) begin
            adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
          end
        end
        sr_d  = {adj[10:0], sr_q[7:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StDone;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign hundreds = sr_q[19:16];
  assign tens     = sr_q[15:12];
  assign ones     = sr_q[11:8];

endmodule

// File: rtl/score_overlay.sv
// Draws the score as three 7-segment decimal digits on the VGA pixel stream.
//   clk_25MHz, reset : pixel clock, asynchronous active-high reset
//   bus (slave)      : score in, pixel stream in/out, busy out
// Score changes are converted to BCD by bin2bcd_seq into a pending set of
// digits; pending digits are shown only from a frame start (x=0,y=0) so a
// frame never mixes old and new digits. Pixel output is registered once.
// Build option SCORE_OVERLAY_BLANK_LEADING_ZERO_EN suppresses leading zeros
// (ones digit always drawn).
module score_overlay
  import score_pkg::*;
#(
  parameter int unsigned X_ORIGIN  = 280,
  parameter int unsigned Y_ORIGIN  = 16,
  parameter int unsigned DIGIT_W   = 16,
  parameter int unsigned DIGIT_H   = 32,
  parameter int unsigned SEG_T     = 4,
  parameter int unsigned DIGIT_GAP = 8,
  parameter logic [11:0] FG_COLOR  = 12'hFFF
) (
  input logic            clk_25MHz,
  input logic            reset,
  score_overlay_if.slave bus
);

  localparam int unsigned CellPitch = DIGIT_W + DIGIT_GAP;
  localparam int unsigned H2        = DIGIT_H / 2;

  logic             conv_start, conv_busy, conv_done;
  bcd_digit_t       conv_h, conv_t, conv_o;
  logic [7:0]       last_score_q;
  // index 0 = hundreds, 1 = tens, 2 = ones
  bcd_digit_t [2:0] pend_q, disp_q;
  logic             pend_valid_q;
  logic             frame_start;
  logic [2:0]       draw_en;
  int unsigned      xi, yi;
  logic             lit;
  logic [11:0]      rgb_d;
  logic             de_q;
  logic [11:0]      rgb_q;

  // Engine is idle exactly when it is not busy, so start is only ever seen in IDLE.
  assign conv_start  = (bus.score != last_score_q) && !conv_busy;
  assign frame_start = (bus.x_pixel == 10'd0) && (bus.y_pixel == 10'd0);

  bin2bcd_seq u_bin2bcd (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .start     (conv_start),
    .bin       (bus.score),
    .busy      (conv_busy),
    .done      (conv_done),
    .hundreds  (conv_h),
    .tens      (conv_t),
    .ones      (conv_o)
  );

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      last_score_q <= '0;
      pend_q       <= '0;
      disp_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      if (conv_start) begin
        last_score_q <= bus.score;
      end
      if (frame_start && pend_valid_q) begin
        disp_q       <= pend_q;
        pend_valid_q <= 1'b0;
      end
      // A fresh result wins over a same-cycle commit, which then waits a frame.
      if (conv_done) begin
        pend_q       <= {conv_o, conv_t, conv_h};
        pend_valid_q <= 1'b1;
      end
    end
  end

`ifdef SCORE_OVERLAY_BLANK_LEADING_ZERO_EN
  assign draw_en[0] = (disp_q[0] != 4'd0);
  assign draw_en[1] = (disp_q[0] != 4'd0) || (disp_q[1] != 4'd0);
  assign draw_en[2] = 1'b1;
`else
  assign draw_en = 3'b111;
`endif

  // Which segment regions contain cell offset (lx, ly); bit order {g..a}.
  function automatic seg7_t seg_regions(int unsigned lx, int unsigned ly);
    seg7_t r;
    r[0] = (ly < SEG_T);
    r[1] = (lx >= DIGIT_W - SEG_T) && (ly < H2);
    r[2] = (lx >= DIGIT_W - SEG_T) && (ly >= H2);
    r[3] = (ly >= DIGIT_H - SEG_T);
    r[4] = (lx < SEG_T) && (ly >= H2);
    r[5] = (lx < SEG_T) && (ly < H2);
    r[6] = (ly >= H2 - SEG_T / 2) && (ly < H2 + SEG_T / 2);
    return r;
  endfunction

  always_comb begin
    xi  = 32'(bus.x_pixel);
    yi  = 32'(bus.y_pixel);
    lit = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (draw_en[i] &&
          (xi >= X_ORIGIN + i * CellPitch) && (xi < X_ORIGIN + i * CellPitch + DIGIT_W) &&
          (yi >= Y_ORIGIN) && (yi < Y_ORIGIN + DIGIT_H)) begin
        lit = lit | (|(seg_regions(xi - X_ORIGIN - i * CellPitch, yi - Y_ORIGIN) &
                       seg7_decode(disp_q[i])));
      end
    end
    if (!bus.de_in) begin
      rgb_d = '0;
    end else if (lit) begin
      rgb_d = FG_COLOR;
    end else begin
      rgb_d = bus.rgb_in;
    end
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      de_q  <= bus.de_in;
      rgb_q <= rgb_d;
    end
  end

  assign bus.de_out  = de_q;
  assign bus.rgb_out = rgb_q;
  assign bus.busy    = conv_busy;

endmodule

// File: tb/tb_score_overlay.sv
module tb_score_overlay;
  localparam int XO = 280, YO = 16, W = 16, H = 32, T = 4, GAP = 8;
  localparam logic [11:0] FG = 12'hFFF;

  logic clk_25MHz = 1'b0;
  logic reset;
  always #20 clk_25MHz = ~clk_25MHz;

  score_overlay_if bus ();

  score_overlay #(
    .X_ORIGIN (XO), .Y_ORIGIN (YO), .DIGIT_W (W), .DIGIT_H (H),
    .SEG_T (T), .DIGIT_GAP (GAP), .FG_COLOR (FG)
  ) dut (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: shown digits, pending digits, last score converted.
  int md[3];
  int mp[3];
  bit mpv;
  int ml;

  function automatic string segs_of(int d);
    case (d)
      0: return "abcdef";
      1: return "bc";
      2: return "abdeg";
      3: return "abcdg";
      4: return "bcfg";
      5: return "acdfg";
      6: return "acdefg";
      7: return "abc";
      8: return "abcdefg";
      9: return "abcdfg";
      default: return "";
    endcase
  endfunction

  function automatic bit in_region(byte s, int lx, int ly);
    case (s)
      "a": return ly < T;
      "d": return ly >= H - T;
      "g": return (ly >= H/2 - T/2) && (ly < H/2 + T/2);
      "f": return (lx < T) && (ly < H/2);
      "e": return (lx < T) && (ly >= H/2);
      "b": return (lx >= W - T) && (ly < H/2);
      "c": return (lx >= W - T) && (ly >= H/2);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [11:0] model_pix(int x, int y, bit de, logic [11:0] rgb);
    string s;
    bit shown;
    int left;
    if (!de) return 12'h000;
    for (int i = 0; i < 3; i++) begin
      left = XO + i * (W + GAP);
      if (x >= left && x < left + W && y >= YO && y < YO + H) begin
        shown = 1'b1;
`ifdef SCORE_OVERLAY_BLANK_LEADING_ZERO_EN
        if (i == 0 && md[0] == 0) shown = 1'b0;
        if (i == 1 && md[0] == 0 && md[1] == 0) shown = 1'b0;
`endif
        if (shown) begin
          s = segs_of(md[i]);
          for (int k = 0; k < s.len(); k++)
            if (in_region(s[k], x - left, y - YO)) return FG;
        end
      end
    end
    return rgb;
  endfunction

  task automatic step();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic idle_inputs();
    bus.x_pixel = 10'd639;
    bus.y_pixel = 10'd479;
    bus.de_in   = 1'b0;
    bus.rgb_in  = 12'h000;
  endtask

  task automatic drive(int x, int y, bit de, logic [11:0] rgb);
    bus.x_pixel = 10'(x);
    bus.y_pixel = 10'(y);
    bus.de_in   = de;
    bus.rgb_in  = rgb;
    step();
  endtask

  task automatic frame_start();
    drive(0, 0, 1'b1, 12'(($urandom)));
    if (mpv) begin
      md  = mp;
      mpv = 1'b0;
    end
    idle_inputs();
  endtask

  // Applies a score and returns how many cycles busy was seen high (bounded).
  task automatic run_conversion(int v, output bit first_busy, output int ncyc);
    bus.score = 8'(v);
    step();
    first_busy = bus.busy;
    ncyc = 0;
    while (bus.busy && ncyc < 100) begin
      ncyc++;
      step();
    end
    if (v != ml) begin
      ml  = v;
      mp  = '{v / 100, (v / 10) % 10, v % 10};
      mpv = 1'b1;
    end
  endtask

  task automatic test_reset();
    int bcnt;
    logic [11:0] exp, rgb;
    reset = 1'b1;
    bus.score = 8'd0;
    idle_inputs();
    md = '{0, 0, 0}; mp = '{0, 0, 0}; mpv = 1'b0; ml = 0;
    step(); step();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++;
    if (bus.de_out !== 1'b0) begin bad++; $display("FAIL reset_de_out got=%b want=0", bus.de_out); end
    total++;
    if (bus.rgb_out !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", bus.rgb_out); end
    reset = 1'b0;
    bcnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.busy) bcnt++;
    end
    total++;
    if (bcnt != 0) begin bad++; $display("FAIL reset_zero_noconv got=%0d want=0", bcnt); end
    // Segment a of the hundreds cell, top-left pixel.
    exp = model_pix(XO, YO, 1'b1, 12'h123);
    drive(XO, YO, 1'b1, 12'h123);
    total++;
    if (bus.rgb_out !== exp) begin bad++; $display("FAIL reset_origin got=%h want=%h", bus.rgb_out, exp); end
    for (int y = 12; y < 52; y += 3) begin
      for (int x = 276; x < 354; x += 3) begin
        rgb = 12'($urandom);
        exp = model_pix(x, y, 1'b1, rgb);
        drive(x, y, 1'b1, rgb);
        total++;
        if (bus.rgb_out !== exp) begin
          bad++; $display("FAIL reset_scan x=%0d y=%0d got=%h want=%h", x, y, bus.rgb_out, exp);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_convert_137();
    bit fb;
    int n;
    logic [11:0] exp, rgb;
    int x, y;
    run_conversion(137, fb, n);
    total++;
    if (fb !== 1'b1) begin bad++; $display("FAIL c137_busy_latency got=%b want=1", fb); end
    total++;
    if (n != 9) begin bad++; $display("FAIL c137_busy_len got=%0d want=9", n); end
    // Pending only: display still shows the old digits.
    for (int k = 0; k < 40; k++) begin
      x = $urandom_range(352, 272); y = $urandom_range(52, 10); rgb = 12'($urandom);
      exp = model_pix(x, y, 1'b1, rgb);
      drive(x, y, 1'b1, rgb);
      total++;
      if (bus.rgb_out !== exp) begin
        bad++; $display("FAIL c137_precommit x=%0d y=%0d got=%h want=%h", x, y, bus.rgb_out, exp);
      end
    end
    idle_inputs();
    frame_start();
    for (int k = 0; k < 80; k++) begin
      x = $urandom_range(352, 272); y = $urandom_range(52, 10); rgb = 12'($urandom);
      exp = model_pix(x, y, 1'b1, rgb);
      drive(x, y, 1'b1, rgb);
      total++;
      if (bus.rgb_out !== exp) begin
        bad++; $display("FAIL c137_frame x=%0d y=%0d got=%h want=%h", x, y, bus.rgb_out, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int bcnt;
    logic [11:0] exp, rgb;
    int x, y;
    bcnt = 0;
    bus.score = 8'd10;
    for (int k = 0; k < 45; k++) begin
      step();
      if (bus.busy) bcnt++;
      if (k == 2) bus.score = 8'd11;
    end
    total++;
    if (bcnt != 18) begin bad++; $display("FAIL b2b_busy_total got=%0d want=18", bcnt); end
    ml = 11; mp = '{0, 1, 1}; mpv = 1'b1;
    frame_start();
    for (int k = 0; k < 80; k++) begin
      x = $urandom_range(352, 272); y = $urandom_range(52, 10); rgb = 12'($urandom);
      exp = model_pix(x, y, 1'b1, rgb);
      drive(x, y, 1'b1, rgb);
      total++;
      if (bus.rgb_out !== exp) begin
        bad++; $display("FAIL b2b_frame x=%0d y=%0d got=%h want=%h", x, y, bus.rgb_out, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_values();
    int vals[4] = '{255, 99, 7, 100};
    bit fb;
    int n;
    logic [11:0] exp, rgb;
    int x, y;
    bit de;
    for (int j = 0; j < 10; j++) begin
      int v;
      if (j < 4) v = vals[j];
      else begin
        v = $urandom_range(255, 0);
        while (v == ml) v = $urandom_range(255, 0);
      end
      run_conversion(v, fb, n);
      total++;
      if (n != 9) begin bad++; $display("FAIL val_busy_len v=%0d got=%0d want=9", v, n); end
      frame_start();
      // Top-left of hundreds segment a: blank only when the macro is defined.
      exp = model_pix(XO + 1, YO + 1, 1'b1, 12'h456);
      drive(XO + 1, YO + 1, 1'b1, 12'h456);
      total++;
      if (bus.rgb_out !== exp) begin
        bad++; $display("FAIL val_hund_a v=%0d got=%h want=%h", v, bus.rgb_out, exp);
      end
      for (int k = 0; k < 60; k++) begin
        x = $urandom_range(352, 272); y = $urandom_range(52, 10);
        rgb = 12'($urandom); de = ($urandom_range(7, 0) != 0);
        exp = model_pix(x, y, de, rgb);
        drive(x, y, de, rgb);
        total++;
        if (bus.rgb_out !== exp) begin
          bad++;
          $display("FAIL val_frame v=%0d x=%0d y=%0d de=%b got=%h want=%h",
                   v, x, y, de, bus.rgb_out, exp);
        end
      end
      idle_inputs();
    end
  endtask

  task automatic test_de();
    bit fb;
    int n;
    bit de;
    logic [11:0] exp;
    run_conversion(188, fb, n);
    frame_start();
    // Ones cell, segment a: lit for digit 8.
    drive(XO + 2 * (W + GAP) + 3, YO + 1, 1'b0, 12'h0F0);
    total++;
    if (bus.rgb_out !== 12'h000) begin bad++; $display("FAIL de_off_lit got=%h want=000", bus.rgb_out); end
    total++;
    if (bus.de_out !== 1'b0) begin bad++; $display("FAIL de_off_de got=%b want=0", bus.de_out); end
    drive(XO + 2 * (W + GAP) + 3, YO + 1, 1'b1, 12'h0F0);
    total++;
    if (bus.rgb_out !== FG) begin bad++; $display("FAIL de_on_lit got=%h want=%h", bus.rgb_out, FG); end
    for (int k = 0; k < 12; k++) begin
      de = $urandom_range(1, 0);
      exp = model_pix(100, 200, de, 12'h3C5);
      drive(100, 200, de, 12'h3C5);
      total++;
      if (bus.de_out !== de || bus.rgb_out !== exp) begin
        bad++;
        $display("FAIL de_track k=%0d got=%b/%h want=%b/%h", k, bus.de_out, bus.rgb_out, de, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit fb;
    int n;
    logic [11:0] exp, rgb;
    int x, y;
    bus.score = 8'd200;
    bus.de_in = 1'b1;
    bus.rgb_in = 12'hABC;
    step(); step(); step();
    reset = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
    total++;
    if (bus.rgb_out !== 12'h000) begin bad++; $display("FAIL rmid_rgb got=%h want=000", bus.rgb_out); end
    md = '{0, 0, 0}; mpv = 1'b0; ml = 0;
    idle_inputs();
    bus.score = 8'd42;
    step();
    reset = 1'b0;
    run_conversion(42, fb, n);
    total++;
    if (n != 9) begin bad++; $display("FAIL rmid_busy_len got=%0d want=9", n); end
    for (int k = 0; k < 30; k++) begin
      x = $urandom_range(352, 272); y = $urandom_range(52, 10); rgb = 12'($urandom);
      exp = model_pix(x, y, 1'b1, rgb);
      drive(x, y, 1'b1, rgb);
      total++;
      if (bus.rgb_out !== exp) begin
        bad++; $display("FAIL rmid_precommit x=%0d y=%0d got=%h want=%h", x, y, bus.rgb_out, exp);
      end
    end
    idle_inputs();
    frame_start();
    for (int k = 0; k < 80; k++) begin
      x = $urandom_range(352, 272); y = $urandom_range(52, 10); rgb = 12'($urandom);
      exp = model_pix(x, y, 1'b1, rgb);
      drive(x, y, 1'b1, rgb);
      total++;
      if (bus.rgb_out !== exp) begin
        bad++; $display("FAIL rmid_frame x=%0d y=%0d got=%h want=%h", x, y, bus.rgb_out, exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    bus.score = 8'd0;
    idle_inputs();
    test_reset();
    test_convert_137();
    test_back_to_back();
    test_values();
    test_de();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_overlay.md
# score_overlay

Renders the current 8-bit score from the score calculator as three 7-segment-style decimal digits onto the VGA pixel stream at 25 MHz. The block sits directly downstream of the score calculator and in line with the RGB path before the VGA output. It converts binary to BCD with a sequential shift-add-3 engine, holds the result, and swaps the displayed digits only at frame start so a frame never tears.

## Interface
- X_ORIGIN, 280: x of hundreds-digit cell left edge.
- Y_ORIGIN, 16: y of digit cell top edge.
- DIGIT_W, 16: digit cell width, pixels.
- DIGIT_H, 32: digit cell height, pixels (even).
- SEG_T, 4: segment thickness, pixels (even, < DIGIT_W/2).
- DIGIT_GAP, 8: horizontal gap between cells.
- FG_COLOR, 12'hFFF: 4:4:4 colour of lit segments.
- clk_25MHz  in  1  pixel clock.
- reset  in  1  reset, asynchronous, active-high; clock clk_25MHz.
- score  in  8  binary score from score calculator.
- x_pixel  in  10  current pixel column.
- y_pixel  in  10  current pixel row.
- de_in  in  1  display enable for current pixel.
- rgb_in  in  12  upstream pixel colour, 4:4:4.
- de_out  out  1  de_in delayed 1 cycle.
- rgb_out  out  12  composited pixel, 1 cycle after inputs.
- busy  out  1  BCD conversion in progress.

## Operation
- Conversion FSM states: IDLE, SHIFT, DONE.
- IDLE: if score != last_score, latch score into shift reg and last_score, clear BCD accumulators, shift count = 0, go to SHIFT.
- SHIFT: per cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left 1; count+1; after 8th shift go to DONE.
- DONE: copy hundreds/tens/ones into pending digits, set pending_valid, go to IDLE.
- busy = 1 in SHIFT and DONE only.
- A score change during SHIFT/DONE is not aborted. IDLE detects the mismatch on return and reconverts.
- Commit: on a cycle with x_pixel==0 and y_pixel==0 and pending_valid, copy pending to displayed digits and clear pending_valid. If DONE sets pending on that same cycle, the commit waits for the next frame.
- Cell i (0 = hundreds, 1 = tens, 2 = ones) spans x in [X_ORIGIN+i*(DIGIT_W+DIGIT_GAP), +DIGIT_W) and y in [Y_ORIGIN, Y_ORIGIN+DIGIT_H). lx and ly are offsets within the cell. H2 = DIGIT_H/2.
- Segment regions:
  - a: ly < SEG_T.
  - d: ly >= DIGIT_H-SEG_T.
  - g: H2-SEG_T/2 <= ly < H2+SEG_T/2.
  - f: lx < SEG_T, ly < H2.
  - e: lx < SEG_T, ly >= H2.
  - b: lx >= DIGIT_W-SEG_T, ly < H2.
  - c: lx >= DIGIT_W-SEG_T, ly >= H2.
- Standard 7-segment encoding for 0-9. Nibble values 10-15 light no segment and must never occur.
- Pixel is lit when it lies in a cell, in a region, and that segment is on for the displayed digit.
- rgb_out: 0 if de_in=0; FG_COLOR if lit; otherwise rgb_in.

## Timing
- Pixel path: 1-cycle registered latency; de_out and rgb_out align with inputs of the previous cycle.
- Score change to busy=1: 1 cycle. SHIFT lasts 8 cycles and DONE 1, so busy is high for 9 cycles.
- Pending to display: next x=0,y=0 cycle, then 1 further cycle to appear on rgb_out.
- Reset values:
  - FSM IDLE, last_score 0, pending_valid 0.
  - Displayed and pending digits 0,0,0.
  - busy 0, de_out 0, rgb_out 0.
- Reset mid-conversion discards the conversion. After release, a nonzero score triggers reconversion.
- Score 0 after reset causes no conversion; display already shows 000.

## Configuration
- SCORE_OVERLAY_BLANK_LEADING_ZERO_EN defined:
  - Hundreds digit is unlit when it is 0.
  - Tens digit is unlit when hundreds and tens are both 0.
  - Ones digit is always drawn.
- Not defined: all three digits are always drawn, e.g. "007".

## Structure
- Shared package score_pkg holds:
  - typedef bcd_digit_t (logic [3:0]).
  - typedef seg7_t (logic [6:0], bit order g..a).
  - constant SEG7_LUT[10] with the digit encodings.
  - conversion FSM enum.
- Sub-module bin2bcd_seq: the IDLE/SHIFT/DONE engine. Ports: clk_25MHz, reset, start, bin[7:0], busy, done, hundreds, tens, ones. The top keeps change detection, commit logic and pixel compositing.

## Test plan
- Reset, score=0, full frame -> cells show 000 (blank-EN: only "0" in ones); pixel (X_ORIGIN,Y_ORIGIN) on segment a = FG_COLOR; out-of-cell pixels = rgb_in, 1-cycle delayed.
- score 0->137 mid-frame -> busy high exactly 9 cycles; display still 000 until the next x=0,y=0; following frame shows 1,3,7.
- score 255 -> digits 2,5,5; score 99 -> 0,9,9, hundreds blank only with the macro defined.
- score changes 10->11 during SHIFT -> first conversion completes (10), IDLE reconverts, next committed frame shows 011 (or the latest).
- de_in=0 inside a lit segment -> rgb_out=0; de_out tracks de_in with 1-cycle delay.
- Assert reset mid-SHIFT -> busy=0, rgb_out=0 immediately; after release with score=42, display shows 042 after the next frame start.
